alu_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit alongside the combinational ALU in the datapath. It executes signed and unsigned multiply and divide over WIDTH-bit operands in a fixed number of cycles and holds results in HI/LO registers until the next operation completes. The control unit stalls on `busy` and reads `hi`/`lo` once `done` pulses.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_muldiv.sv | 181 ++++++++++++++++++
 tb/tb_alu_muldiv.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the multiply/divide unit and the control decoder.
package alu_pkg;

  // Opcode encodings, shared with the control decoder.
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    OpMultu = OP_MULTU,
    OpMult  = OP_MULT,
    OpDivu  = OP_DIVU,
    OpDiv   = OP_DIV
  } muldiv_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } muldiv_state_t;

  // Bit 1 of the opcode selects divide, bit 0 selects signed.
  function automatic logic op_is_div(muldiv_op_t o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(muldiv_op_t o);
    return o[0];
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply / restoring divide unit with HI/LO result registers.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             overflow
);

  muldiv_state_t      state_q, state_d;
  muldiv_op_t         op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;   // product, or {unused, dividend/quotient}
  logic [WIDTH:0]     rem_q, rem_d;   // partial remainder, one spare bit for the trial subtract
  logic [WIDTH-1:0]   opb_q, opb_d;   // |multiplicand| or |divisor|
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;

  muldiv_op_t         op_in;
  logic               sgn_in, div_in, a_neg, b_neg, ovf_in;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH+1:0]   add_x, add_y, add_s;
  logic               add_sub;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  // Operand decode at the start edge: magnitudes, signs and the DIV overflow case.
  always_comb begin
    op_in  = muldiv_op_t'(op);
    sgn_in = op_is_signed(op_in);
    div_in = op_is_div(op_in);
    a_neg  = sgn_in & a[WIDTH-1];
    b_neg  = sgn_in & b[WIDTH-1];
    a_abs  = a_neg ? (~a + 1'b1) : a;
    b_abs  = b_neg ? (~b + 1'b1) : b;
    ovf_in = (op_in == OpDiv) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
  end

  // Shared adder: shift-add for multiply, trial subtract for divide.
  always_comb begin
    add_x   = {2'b00, acc_q[2*WIDTH-1:WIDTH]};
    add_y   = {2'b00, opb_q};
    add_sub = 1'b0;
    if (op_is_div(op_q)) begin
      add_x   = {rem_q, acc_q[WIDTH-1]};
      add_sub = 1'b1;
    end
    add_s = add_x + (add_y ^ {(WIDTH+2){add_sub}}) + {{(WIDTH+1){1'b0}}, add_sub};
  end

  // Sign correction and special-case results written back in FIX.
  always_comb begin
    fix_hi = '0;
    fix_lo = '0;
    if (dbz_q) begin
      fix_hi = acc_q[WIDTH-1:0];
      fix_lo = '1;
    end else if (op_is_div(op_q)) begin
      fix_lo = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
      fix_hi = neg_rem_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
    end else begin
      {fix_hi, fix_lo} = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    end
  end

  // Next-state and iteration step.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opb_d     = opb_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          op_d      = op_in;
          cnt_d     = '0;
          rem_d     = '0;
          opb_d     = b_abs;
          acc_d     = {{WIDTH{1'b0}}, a_abs};
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dbz_d     = 1'b0;
          ovf_d     = ovf_in;
          state_d   = StRun;
          if (div_in && (b == '0)) begin
            // Skip iteration; FIX returns the raw dividend in hi.
            acc_d   = {{WIDTH{1'b0}}, a};
            dbz_d   = 1'b1;
            state_d = StFix;
          end
        end
      end
      StRun: begin
        if (op_is_div(op_q)) begin
          // Negative trial result means restore (keep the shifted remainder).
          rem_d              = add_s[WIDTH+1] ? add_x[WIDTH:0] : add_s[WIDTH:0];
          acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], ~add_s[WIDTH+1]};
        end else begin
          acc_d = acc_q[0] ? {add_s[WIDTH:0], acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFix: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= OpMultu;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opb_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opb_q     <= opb_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv at WIDTH=32.
module tb_alu_muldiv;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, div_by_zero, overflow;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    logic         ovf;
  } res_t;

  res_t sb[$];

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  // Reference results from plain 64-bit arithmetic.
  function automatic res_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    res_t r;
    logic [63:0] p;
    longint sx, sy, q, m;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0;
    case (o)
      2'b00: begin p = {32'b0, x} * {32'b0, y}; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'b01: begin p = 64'(sx * sy); r.hi = p[63:32]; r.lo = p[31:0]; end
      default: begin
        if (y == '0) begin
          r.hi = x; r.lo = '1; r.dbz = 1'b1;
        end else if (o == 2'b10) begin
          r.lo = x / y; r.hi = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          r.lo = 32'h8000_0000; r.hi = '0; r.ovf = 1'b1;
        end else begin
          q = sx / sy; m = sx % sy;
          r.lo = q[31:0]; r.hi = m[31:0];
        end
      end
    endcase
    return r;
  endfunction

  // Drive one start pulse across edge E0 and queue its expected result.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input res_t exp);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back(exp);
  endtask

  // Count cycles after E0 until done is seen, bounded by budget.
  task automatic wait_done(input int budget, output int cycles, output bit timed_out);
    cycles = 0;
    timed_out = 1'b1;
    while (cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    total++;
    if ({busy, done, hi, lo, div_by_zero, overflow} !== '0) begin
      bad++;
      $display("FAIL reset_state got busy=%b done=%b hi=%h lo=%h dbz=%b ovf=%b want all zero",
               busy, done, hi, lo, div_by_zero, overflow);
    end
  endtask

  task automatic test_mul;
    logic [1:0]   ops[5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [W-1:0] as[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [W-1:0] bs[5]  = '{32'hFFFF_FFFF, 32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
    res_t         ex[5]  = '{{32'hFFFF_FFFE, 32'h0000_0001, 2'b00},
                             {32'hFFFF_FFFF, 32'hFFFF_FFEB, 2'b00},
                             {32'h4000_0000, 32'h0000_0000, 2'b00},
                             {32'h0000_0000, 32'h0000_0001, 2'b00},
                             {32'h0000_0000, 32'h0000_0000, 2'b00}};
    int cyc;
    bit to;
    res_t e, g;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i], ex[i]);
      wait_done(40, cyc, to);
      e = sb.pop_front();
      g = {hi, lo, div_by_zero, overflow};
      total++;
      if (to || cyc != 33) begin
        bad++;
        $display("FAIL mul_latency[%0d] got %0d cycles (timeout=%b) want 33", i, cyc, to);
      end
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL mul_result[%0d] got hi=%h lo=%h dbz=%b ovf=%b want hi=%h lo=%h dbz=%b ovf=%b",
                 i, g.hi, g.lo, g.dbz, g.ovf, e.hi, e.lo, e.dbz, e.ovf);
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || {hi, lo} !== {e.hi, e.lo}) begin
        bad++;
        $display("FAIL mul_pulse[%0d] got done=%b busy=%b hi=%h lo=%h want done=0 busy=0 held result",
                 i, done, busy, hi, lo);
      end
    end
  endtask

  task automatic test_div;
    logic [1:0]   ops[8] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11};
    logic [W-1:0] as[8]  = '{32'hFFFF_FFF9, 32'd9, 32'd7, 32'hFFFF_FFF8, 32'd100,
                             32'h8000_0000, 32'd9, 32'hFFFF_FFFB};
    logic [W-1:0] bs[8]  = '{32'd2, 32'd4, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0,
                             32'hFFFF_FFFF, 32'd4, 32'd0};
    res_t         ex[8]  = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD, 2'b00},
                             {32'h0000_0001, 32'h0000_0002, 2'b00},
                             {32'h0000_0001, 32'hFFFF_FFFD, 2'b00},
                             {32'hFFFF_FFFE, 32'h0000_0002, 2'b00},
                             {32'h0000_0064, 32'hFFFF_FFFF, 2'b10},
                             {32'h0000_0000, 32'h8000_0000, 2'b01},
                             {32'h0000_0001, 32'h0000_0002, 2'b00},
                             {32'hFFFF_FFFB, 32'hFFFF_FFFF, 2'b10}};
    int           lat[8] = '{33, 33, 33, 33, 1, 33, 33, 1};
    int cyc;
    bit to;
    res_t e, g;
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i], ex[i]);
      wait_done(40, cyc, to);
      e = sb.pop_front();
      g = {hi, lo, div_by_zero, overflow};
      total++;
      if (to || cyc != lat[i]) begin
        bad++;
        $display("FAIL div_latency[%0d] got %0d cycles (timeout=%b) want %0d", i, cyc, to, lat[i]);
      end
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL div_result[%0d] got hi=%h lo=%h dbz=%b ovf=%b want hi=%h lo=%h dbz=%b ovf=%b",
                 i, g.hi, g.lo, g.dbz, g.ovf, e.hi, e.lo, e.dbz, e.ovf);
      end
      // Flags stay sticky while idle.
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({div_by_zero, overflow} !== {e.dbz, e.ovf} || done !== 1'b0) begin
        bad++;
        $display("FAIL div_sticky[%0d] got dbz=%b ovf=%b done=%b want dbz=%b ovf=%b done=0",
                 i, div_by_zero, overflow, done, e.dbz, e.ovf);
      end
    end
  endtask

  task automatic test_ignored_start;
    int cyc;
    bit to;
    res_t e, g;
    issue(2'b00, 32'd1000, 32'd1000, '{hi: 32'h0, lo: 32'h000F_4240, dbz: 1'b0, ovf: 1'b0});
    repeat (9) @(posedge clk);
    #1;
    op = 2'b11; a = 32'd5; b = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, cyc, to);
    e = sb.pop_front();
    g = {hi, lo, div_by_zero, overflow};
    total++;
    if (to || cyc != 23) begin
      bad++;
      $display("FAIL ignored_start_latency got %0d cycles after E10 (timeout=%b) want 23", cyc, to);
    end
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL ignored_start_result got hi=%h lo=%h dbz=%b ovf=%b want hi=%h lo=%h dbz=%b ovf=%b",
               g.hi, g.lo, g.dbz, g.ovf, e.hi, e.lo, e.dbz, e.ovf);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit to;
    res_t e, g;
    issue(2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFE, '{hi: 32'h0, lo: 32'h4, dbz: 1'b0, ovf: 1'b0});
    wait_done(40, cyc, to);
    e = sb.pop_front();
    g = {hi, lo, div_by_zero, overflow};
    total++;
    if (to || g !== e) begin
      bad++;
      $display("FAIL b2b_first got hi=%h lo=%h (timeout=%b) want hi=%h lo=%h", g.hi, g.lo, to, e.hi, e.lo);
    end
    // Start during the done cycle must be accepted.
    issue(2'b10, 32'd100, 32'd7, '{hi: 32'd2, lo: 32'd14, dbz: 1'b0, ovf: 1'b0});
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept got done=%b busy=%b want done=0 busy=1", done, busy);
    end
    wait_done(40, cyc, to);
    e = sb.pop_front();
    g = {hi, lo, div_by_zero, overflow};
    total++;
    if (to || cyc != 33 || g !== e) begin
      bad++;
      $display("FAIL b2b_second got %0d cycles hi=%h lo=%h (timeout=%b) want 33 cycles hi=%h lo=%h",
               cyc, g.hi, g.lo, to, e.hi, e.lo);
    end
  endtask

  task automatic test_reset_abort;
    int cyc;
    bit to;
    bit seen;
    res_t e, g;
    issue(2'b01, 32'h7FFF_FFFF, 32'd3, model(2'b01, 32'h7FFF_FFFF, 32'd3));
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    void'(sb.pop_front());
    total++;
    if ({busy, done, hi, lo, div_by_zero, overflow} !== '0) begin
      bad++;
      $display("FAIL reset_abort_clear got busy=%b done=%b hi=%h lo=%h dbz=%b ovf=%b want all zero",
               busy, done, hi, lo, div_by_zero, overflow);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL reset_abort_nodone got done/busy activity=1 want 0");
    end
    issue(2'b00, 32'd6, 32'd7, '{hi: 32'h0, lo: 32'd42, dbz: 1'b0, ovf: 1'b0});
    wait_done(40, cyc, to);
    e = sb.pop_front();
    g = {hi, lo, div_by_zero, overflow};
    total++;
    if (to || cyc != 33 || g !== e) begin
      bad++;
      $display("FAIL reset_fresh_op got %0d cycles hi=%h lo=%h (timeout=%b) want 33 cycles hi=%h lo=%h",
               cyc, g.hi, g.lo, to, e.hi, e.lo);
    end
  endtask

  task automatic test_random;
    int cyc, want;
    bit to;
    res_t e, g;
    logic [1:0] o;
    logic [W-1:0] x, y;
    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if (i % 4 == 1) y = 32'($urandom_range(0, 3)) - 32'd1;
      if (i % 5 == 2) x = 32'h8000_0000;
      want = (o[1] && y == '0) ? 1 : 33;
      issue(o, x, y, model(o, x, y));
      wait_done(40, cyc, to);
      e = sb.pop_front();
      g = {hi, lo, div_by_zero, overflow};
      total++;
      if (to || cyc != want || g !== e) begin
        bad++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got %0d cyc hi=%h lo=%h dbz=%b ovf=%b want %0d cyc hi=%h lo=%h dbz=%b ovf=%b",
                 i, o, x, y, cyc, g.hi, g.lo, g.dbz, g.ovf, want, e.hi, e.lo, e.dbz, e.ovf);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    reset = 1'b0;
    @(posedge clk); #1;
    test_mul;
    test_div;
    test_ignored_start;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
